// File: rtl/box_anim_sequencer.sv
// Animates a bouncing box through a single-pixel plot port with valid/ready handshake.
// Each move erases the old box, steps it with edge bounce, then redraws it.
module box_anim_sequencer #(
    parameter int unsigned X_MAX           = 160,
    parameter int unsigned Y_MAX           = 120,
    parameter int unsigned BOX_W           = 4,
    parameter int unsigned BOX_H           = 4,
    parameter int unsigned X_INIT          = 0,
    parameter int unsigned Y_INIT          = 60,
    parameter int unsigned FRAMES_PER_MOVE = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [2:0] colour_in,
    input  logic       plot_ready,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       busy,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StDraw  = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StErase = 3'd3;
    localparam logic [2:0] StMove  = 3'd4;

    localparam logic [7:0] X_LAST     = 8'(X_MAX - BOX_W);
    localparam logic [6:0] Y_LAST     = 7'(Y_MAX - BOX_H);
    localparam logic [2:0] OX_LAST    = 3'(BOX_W - 1);
    localparam logic [2:0] OY_LAST    = 3'(BOX_H - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_MOVE - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] pos_x_q, pos_x_d;
    logic [6:0] pos_y_q, pos_y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    logic [2:0] ox_q, ox_d;
    logic [2:0] oy_q, oy_d;
    logic [7:0] frame_q, frame_d;
    logic [2:0] colour_q, colour_d;

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        frame_d  = frame_q;
        colour_d = colour_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    colour_d = colour_in;
                    state_d  = StDraw;
                    ox_d     = 3'd0;
                    oy_d     = 3'd0;
                end
            end
            StDraw, StErase: begin
                // Advance only when the sink consumes the presented pixel.
                if (plot_ready) begin
                    if (ox_q == OX_LAST) begin
                        ox_d = 3'd0;
                        if (oy_q == OY_LAST) begin
                            oy_d    = 3'd0;
                            frame_d = 8'd0;
                            state_d = (state_q == StDraw) ? StWait : StMove;
                        end else begin
                            oy_d = oy_q + 3'd1;
                        end
                    end else begin
                        ox_d = ox_q + 3'd1;
                    end
                end
            end
            StWait: begin
                if (frame_tick) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_d = 8'd0;
                        state_d = StErase;
                        ox_d    = 3'd0;
                        oy_d    = 3'd0;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            StMove: begin
                if (dir_x_q && pos_x_q == X_LAST) begin
                    dir_x_d = 1'b0;
                    pos_x_d = pos_x_q - 8'd1;
                end else if (!dir_x_q && pos_x_q == 8'd0) begin
                    dir_x_d = 1'b1;
                    pos_x_d = 8'd1;
                end else begin
                    pos_x_d = dir_x_q ? pos_x_q + 8'd1 : pos_x_q - 8'd1;
                end
                if (dir_y_q && pos_y_q == Y_LAST) begin
                    dir_y_d = 1'b0;
                    pos_y_d = pos_y_q - 7'd1;
                end else if (!dir_y_q && pos_y_q == 7'd0) begin
                    dir_y_d = 1'b1;
                    pos_y_d = 7'd1;
                end else begin
                    pos_y_d = dir_y_q ? pos_y_q + 7'd1 : pos_y_q - 7'd1;
                end
                colour_d = colour_in;
                state_d  = StDraw;
                ox_d     = 3'd0;
                oy_d     = 3'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pos_x_q  <= 8'(X_INIT);
            pos_y_q  <= 7'(Y_INIT);
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            ox_q     <= 3'd0;
            oy_q     <= 3'd0;
            frame_q  <= 8'd0;
            colour_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            frame_q  <= frame_d;
            colour_q <= colour_d;
        end
    end

    // Outputs decode registered state only; x/y/colour read zero when not plotting.
    always_comb begin
        plot   = (state_q == StDraw) || (state_q == StErase);
        x      = plot ? pos_x_q + {5'd0, ox_q} : 8'd0;
        y      = plot ? pos_y_q + {4'd0, oy_q} : 7'd0;
        colour = (state_q == StDraw) ? colour_q : 3'd0;
        busy   = (state_q != StIdle);
        pos_x  = pos_x_q;
        pos_y  = pos_y_q;
    end

endmodule

// File: tb/tb_box_anim_sequencer.sv
// Self-checking bench: vector table, directed corner sequences and a random run
// checked every cycle against a transaction-style reference model.
module tb_box_anim_sequencer;

    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;
    localparam int BW    = 4;
    localparam int BH    = 4;
    localparam int XI    = 0;
    localparam int YI    = 60;
    localparam int FPM   = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [2:0] colour_in = 3'd0;
    logic       plot_ready = 1'b0;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy;
    logic [7:0] pos_x;
    logic [6:0] pos_y;

    box_anim_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .colour_in  (colour_in),
        .plot_ready (plot_ready),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .busy       (busy),
        .pos_x      (pos_x),
        .pos_y      (pos_y)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 draw, 2 wait, 3 erase, 4 move; k = pixel index.
    int m_phase, m_k, m_fc, m_px, m_py, m_col;
    bit m_dx, m_dy;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_phase = 0; m_k = 0; m_fc = 0; m_col = 0;
            m_px = XI; m_py = YI; m_dx = 1'b1; m_dy = 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin m_col = int'(colour_in); m_phase = 1; m_k = 0; end
                1, 3: if (plot_ready) begin
                    if (m_k == BW * BH - 1) begin
                        m_k = 0; m_fc = 0;
                        m_phase = (m_phase == 1) ? 2 : 4;
                    end else m_k++;
                end
                2: if (frame_tick) begin
                    if (m_fc == FPM - 1) begin m_fc = 0; m_phase = 3; m_k = 0; end
                    else m_fc++;
                end
                default: begin
                    if (m_dx && m_px == X_MAX - BW) begin m_dx = 1'b0; m_px = m_px - 1; end
                    else if (!m_dx && m_px == 0) begin m_dx = 1'b1; m_px = 1; end
                    else m_px = m_dx ? m_px + 1 : m_px - 1;
                    if (m_dy && m_py == Y_MAX - BH) begin m_dy = 1'b0; m_py = m_py - 1; end
                    else if (!m_dy && m_py == 0) begin m_dy = 1'b1; m_py = 1; end
                    else m_py = m_dy ? m_py + 1 : m_py - 1;
                    m_col = int'(colour_in); m_phase = 1; m_k = 0;
                end
            endcase
        end
    endtask

    task automatic check_model();
        bit eplot;
        int ex, ey, ec;
        logic [34:0] exp_v;
        eplot = (m_phase == 1) || (m_phase == 3);
        ex = eplot ? (m_px + m_k % BW) % 256 : 0;
        ey = eplot ? (m_py + m_k / BW) % 128 : 0;
        ec = (m_phase == 1) ? m_col : 0;
        exp_v = {eplot, 8'(ex), 7'(ey), 3'(ec), (m_phase != 0), 8'(m_px), 7'(m_py)};
        check("model", 64'({plot, x, y, colour, busy, pos_x, pos_y}), 64'(exp_v));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        logic       rst, st, tick, rdy;
        logic [2:0] cin;
        logic       eplot;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ecol;
        logic       ebusy;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic [2:0] cin,
                                input logic eplot, input int ex, input int ey,
                                input logic [2:0] ecol, input logic ebusy);
        vec_t v;
        v.rst = rst; v.st = st; v.tick = 1'b0; v.rdy = 1'b1; v.cin = cin;
        v.eplot = eplot; v.ex = 8'(ex); v.ey = 7'(ey); v.ecol = ecol; v.ebusy = ebusy;
        return v;
    endfunction

    vec_t vt[18];
    logic [14:0] got_q[$];
    int cycles, max_px, max_py;
    bit done;

    initial begin
        // First draw pass from reset: pixel i shown on entry i+1.
        vt[0] = mk(1'b1, 1'b0, 3'd0, 1'b0, 0, 0, 3'd0, 1'b0);
        vt[1] = mk(1'b0, 1'b1, 3'd5, 1'b1, 0, 60, 3'd5, 1'b1);
        for (int i = 1; i < 16; i++)
            vt[i + 1] = mk(1'b0, 1'b0, 3'd2, 1'b1, i % 4, 60 + i / 4, 3'd5, 1'b1);
        vt[17] = mk(1'b0, 1'b0, 3'd2, 1'b0, 0, 0, 3'd0, 1'b1);

        for (int i = 0; i < 18; i++) begin
            reset = vt[i].rst; start = vt[i].st; frame_tick = vt[i].tick;
            plot_ready = vt[i].rdy; colour_in = vt[i].cin;
            step();
            check($sformatf("table[%0d]", i), 64'({plot, x, y, colour, busy}),
                  64'({vt[i].eplot, vt[i].ex, vt[i].ey, vt[i].ecol, vt[i].ebusy}));
        end

        // 15 ticks in WAIT trigger ERASE; then MOVE and redraw at (1,61).
        start = 1'b0; frame_tick = 1'b1; plot_ready = 1'b1; colour_in = 3'd2;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 13) check("wait_14_ticks", 64'(plot), 64'(0));
        end
        check("erase_first", 64'({plot, x, y, colour}), 64'({1'b1, 8'd0, 7'd60, 3'd0}));
        frame_tick = 1'b0;
        repeat (16) step();
        check("move_cycle", 64'({plot, busy}), 64'({1'b0, 1'b1}));
        step();
        check("redraw_origin", 64'({plot, x, y, colour, pos_x, pos_y}),
              64'({1'b1, 8'd1, 7'd61, 3'd2, 8'd1, 7'd61}));

        // plot_ready toggling: each pixel held two cycles, none skipped or repeated.
        cycles = 0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            plot_ready = c[0];
            if (!plot) done = 1'b1;
            else begin
                cycles++;
                if (plot_ready) got_q.push_back({x, y});
                step();
            end
        end
        check("toggle_done", 64'(done), 64'(1));
        check("toggle_cycles", 64'(cycles), 64'(32));
        check("toggle_count", 64'(got_q.size()), 64'(16));
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            check($sformatf("toggle_px[%0d]", i), 64'(got_q[i]),
                  64'({8'(1 + i % 4), 7'(61 + i / 4)}));

        // Ticks outside WAIT are dropped; only the 15th tick inside WAIT moves on.
        plot_ready = 1'b1; frame_tick = 1'b1;
        repeat (15) step();
        repeat (33) step();
        check("after_move2", 64'({plot, busy, pos_x, pos_y}),
              64'({1'b0, 1'b1, 8'd2, 7'd62}));
        repeat (14) step();
        check("wait_14_again", 64'(plot), 64'(0));
        frame_tick = 1'b0;
        step();
        check("no_tick_hold", 64'(plot), 64'(0));
        frame_tick = 1'b1;
        step();
        check("tick15_erase", 64'({plot, x, y, colour}), 64'({1'b1, 8'd2, 7'd62, 3'd0}));

        // Reset at pixel 7 of DRAW, then a fresh start redraws from the origin.
        frame_tick = 1'b0;
        repeat (17) step();
        repeat (7) step();
        check("draw_px7", 64'({plot, x, y}), 64'({1'b1, 8'd6, 7'd64}));
        reset = 1'b1;
        step();
        check("reset_mid", 64'({plot, busy, pos_x, pos_y}), 64'({1'b0, 1'b0, 8'd0, 7'd60}));
        reset = 1'b0; start = 1'b1; colour_in = 3'd3;
        step();
        check("restart", 64'({plot, x, y, colour}), 64'({1'b1, 8'd0, 7'd60, 3'd3}));
        start = 1'b0;

        // Random run long enough to bounce off the right and bottom edges.
        max_px = 0; max_py = 0;
        for (int c = 0; c < 30000; c++) begin
            start      = ($urandom_range(0, 7) == 0);
            frame_tick = $urandom_range(0, 1) == 1;
            plot_ready = ($urandom_range(0, 3) != 0);
            colour_in  = 3'($urandom_range(0, 7));
            step();
            if (plot) check("bounds", 64'({x > 8'd159, y > 7'd119}), 64'(0));
            if (int'(pos_x) > max_px) max_px = int'(pos_x);
            if (int'(pos_y) > max_py) max_py = int'(pos_y);
        end
        check("max_pos_x", 64'(max_px), 64'(X_MAX - BW));
        check("max_pos_y", 64'(max_py), 64'(Y_MAX - BH));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
